// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: CPU byte FIFO plus round-robin arbitration
// against a debug byte source in front of the single UART emitter.
module uart_tx_sched #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [7:0]    i_cpu_data,
    input  logic          i_cpu_valid,
    output logic          o_cpu_full,
    output logic [AW:0]   o_cpu_level,
    output logic          o_overflow,
    input  logic          i_ovf_clr,
    input  logic [7:0]    i_dbg_data,
    input  logic          i_dbg_valid,
    output logic          o_dbg_ready,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    output logic          o_busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    state_t        state;
    state_t        state_nx;
    logic          last_cpu;
    logic          last_cpu_nx;
    logic [7:0]    data_nx;
    logic          cpu_req;
    logic          grant_cpu;
    logic          grant_dbg;
    logic          push_ok;
    logic          drop;

    assign cpu_req = (count != '0);
    assign push_ok = i_cpu_valid && ((count != FULL_LVL) || grant_cpu);
    assign drop    = i_cpu_valid && !push_ok;

    // last_cpu=0 after reset, so the CPU wins the first contended grant
    always_comb begin
        state_nx    = state;
        last_cpu_nx = last_cpu;
        data_nx     = o_tx_data;
        grant_cpu   = 1'b0;
        grant_dbg   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && (!i_dbg_valid || !last_cpu)) begin
                    grant_cpu   = 1'b1;
                    data_nx     = mem[rd_ptr];
                    last_cpu_nx = 1'b1;
                    state_nx    = SEND;
                end else if (i_dbg_valid) begin
                    grant_dbg   = 1'b1;
                    data_nx     = i_dbg_data;
                    last_cpu_nx = 1'b0;
                    state_nx    = SEND;
                end
            end
            SEND: begin
                if (i_tx_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            last_cpu   <= 1'b0;
            o_tx_data  <= 8'h00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            state     <= state_nx;
            last_cpu  <= last_cpu_nx;
            o_tx_data <= data_nx;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_cpu) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !grant_cpu) begin
                count <= count + 1'b1;
            end else if (!push_ok && grant_cpu) begin
                count <= count - 1'b1;
            end
            // a drop in the same cycle as a clear keeps the flag set
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                o_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_cpu_data;
        end
    end

    assign o_cpu_full  = (count == FULL_LVL);
    assign o_cpu_level = count;
    assign o_dbg_ready = grant_dbg;
    assign o_tx_valid  = (state == SEND);
    assign o_busy      = cpu_req || (state == SEND) || !i_tx_ready;

endmodule
